// File: rtl/solve_seq_ctrl_pkg.sv
// solve_seq_ctrl_pkg: shared state, error-bit and point types for the solver run sequencer
package solve_seq_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, DONE} seq_state_e;
    localparam int ERR_ABORT = 0;
    localparam int ERR_TMO   = 1;
    localparam int ERR_PROTO = 2;
    localparam int PT_DIM_W  = 17;
    typedef struct packed {
        logic [PT_DIM_W-1:0] x;
        logic [PT_DIM_W-1:0] y;
        logic [PT_DIM_W-1:0] z;
    } point_t;
endpackage

// File: rtl/solve_seq_ctrl_point_buf.sv
// point_buf: simple dual-port point RAM, synchronous write, registered 1-cycle read
module point_buf #(
    parameter int DEPTH = 1000,
    parameter int W     = 51,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
        rd_data <= r_mem[rd_addr];
    end
endmodule

// File: rtl/solve_seq_ctrl.sv
// solve_seq_ctrl: buffers a point set, clears the datapath, replays the points and collects the answer
module solve_seq_ctrl
    import solve_seq_ctrl_pkg::*;
#(
    parameter int NUM_POINTS = 1000,
    parameter int DIM_W      = 17,
    parameter int ANSWER_W   = 30,
    parameter int TMO_W      = 32,
    parameter int CLR_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIM_W-1:0]                  ld_x,
    input  logic [DIM_W-1:0]                  ld_y,
    input  logic [DIM_W-1:0]                  ld_z,
    input  logic                              ld_vld,
    output logic                              ld_rdy,
    input  logic                              buf_clr,
    input  logic                              start,
    input  logic                              abort,
    input  logic [TMO_W-1:0]                  tmo_cycles,
    output logic                              dp_clr,
    output logic [DIM_W-1:0]                  xloc,
    output logic [DIM_W-1:0]                  yloc,
    output logic [DIM_W-1:0]                  zloc,
    output logic                              locs_vld,
    input  logic                              locs_rdy,
    input  logic [ANSWER_W-1:0]               dp_answer,
    input  logic                              dp_answer_vld,
    output logic                              busy,
    output logic                              done,
    output logic [ANSWER_W-1:0]               answer,
    output logic [2:0]                        err,
    output logic [$clog2(NUM_POINTS+1)-1:0]   pt_cnt
);
    localparam int PW  = $clog2(NUM_POINTS+1);
    localparam int AW  = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1;
    localparam int PTW = 3*DIM_W;
    localparam int CW  = $clog2(CLR_CYCLES+1);
    localparam logic [PW-1:0] NP   = PW'(NUM_POINTS);
    localparam logic [PW-1:0] NPM1 = PW'(NUM_POINTS-1);
    localparam logic [CW-1:0] CL   = CW'(CLR_CYCLES-1);

    seq_state_e          r_state;
    logic [PW-1:0]       r_pt_cnt, r_rd_ptr, r_hs_cnt;
    logic [CW-1:0]       r_clr_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_tmo_en, r_abort_run, r_rd_pend;
    logic [1:0]          r_sk_cnt;
    logic [PTW-1:0]      r_sk0, r_sk1;
    logic [ANSWER_W-1:0] r_answer;
    logic [2:0]          r_err;
    logic [PTW-1:0]      w_rd_data;
    logic                w_ld, w_start_ok, w_pop, w_issue;

    assign ld_rdy     = !rst && r_state == IDLE && r_pt_cnt < NP;
    assign w_ld       = ld_vld && ld_rdy && !buf_clr;
    assign w_start_ok = start && r_pt_cnt == NP;
    assign busy       = r_state != IDLE;
    assign dp_clr     = r_state == CLEAR;
    assign done       = r_state == DONE;
    assign locs_vld   = r_state == STREAM && r_sk_cnt != 2'd0;
    assign {xloc, yloc, zloc} = r_sk0;
    assign w_pop      = locs_vld && locs_rdy;
    // a read is issued only if the skid plus the in-flight read can still hold it after this cycle's pop
    assign w_issue    = r_state == STREAM && r_rd_ptr < NP &&
                        ({1'b0, r_sk_cnt} + 3'(r_rd_pend)) < (3'd2 + 3'(w_pop));
    assign answer     = r_answer;
    assign err        = r_err;
    assign pt_cnt     = r_pt_cnt;

    point_buf #(.DEPTH(NUM_POINTS), .W(PTW), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (w_ld),
        .wr_addr (r_pt_cnt[AW-1:0]),
        .wr_data ({ld_x, ld_y, ld_z}),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pt_cnt <= '0;
        else if (r_state == IDLE && buf_clr) r_pt_cnt <= '0;
        else if (w_ld) r_pt_cnt <= r_pt_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_hs_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_sk_cnt  <= '0;
            r_sk0     <= '0;
            r_sk1     <= '0;
        end else if (r_state != STREAM) begin
            r_rd_ptr  <= '0;
            r_hs_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_sk_cnt  <= '0;
        end else begin
            r_rd_pend <= w_issue;
            r_sk_cnt  <= r_sk_cnt + 2'(r_rd_pend) - 2'(w_pop);
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_pop) begin
                r_hs_cnt <= r_hs_cnt + 1'b1;
                r_sk0    <= r_sk1;
            end
            if (r_rd_pend) begin
                if (r_sk_cnt - 2'(w_pop) == 2'd0) r_sk0 <= w_rd_data;
                else r_sk1 <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_tmo       <= '0;
            r_tmo_en    <= 1'b0;
            r_abort_run <= 1'b0;
            r_err       <= '0;
            r_answer    <= '0;
        end else begin
            if (dp_answer_vld && r_state != WAIT) r_err[ERR_PROTO] <= 1'b1;
            if (r_state == IDLE) begin
                if (w_start_ok) begin
                    r_err       <= {dp_answer_vld, 2'b00};
                    r_tmo       <= tmo_cycles;
                    r_tmo_en    <= tmo_cycles != '0;
                    r_abort_run <= 1'b0;
                    r_clr_cnt   <= '0;
                    r_state     <= CLEAR;
                end else if (start) r_err[ERR_PROTO] <= 1'b1;
            end else if (abort) begin
                r_err[ERR_ABORT] <= 1'b1;
                r_abort_run      <= 1'b1;
                r_clr_cnt        <= '0;
                r_state          <= CLEAR;
            end else begin
                case (r_state)
                    CLEAR: begin
                        if (r_clr_cnt == CL) r_state <= r_abort_run ? IDLE : STREAM;
                        else r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                    STREAM: if (w_pop && r_hs_cnt == NPM1) r_state <= WAIT;
                    WAIT: begin
                        if (dp_answer_vld) begin
                            r_answer <= dp_answer;
                            r_state  <= DONE;
                        end else if (r_tmo_en && r_tmo == TMO_W'(1)) begin
                            r_err[ERR_TMO] <= 1'b1;
                            r_state        <= IDLE;
                        end else r_tmo <= r_tmo - 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_solve_seq_ctrl.sv
// tb_solve_seq_ctrl: scoreboard bench for the run sequencer with a 4-point buffer
module tb_solve_seq_ctrl;
    import solve_seq_ctrl_pkg::*;
    localparam int NP = 4;
    localparam int DW = 17;
    localparam int AW = 30;

    logic          clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] ld_x = '0, ld_y = '0, ld_z = '0, xloc, yloc, zloc;
    logic          ld_vld = 1'b0, ld_rdy, buf_clr = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0]   tmo_cycles = '0;
    logic          dp_clr, locs_vld, locs_rdy = 1'b0, dp_answer_vld = 1'b0, busy, done;
    logic [AW-1:0] dp_answer = '0, answer;
    logic [2:0]    err, pt_cnt;

    int     n_vec = 0, n_err = 0, mcnt = 0;
    point_t mdl [NP];
    point_t exp_q [$];

    solve_seq_ctrl #(.NUM_POINTS(NP)) dut (
        .clk(clk), .rst(rst), .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z), .ld_vld(ld_vld),
        .ld_rdy(ld_rdy), .buf_clr(buf_clr), .start(start), .abort(abort),
        .tmo_cycles(tmo_cycles), .dp_clr(dp_clr), .xloc(xloc), .yloc(yloc), .zloc(zloc),
        .locs_vld(locs_vld), .locs_rdy(locs_rdy), .dp_answer(dp_answer),
        .dp_answer_vld(dp_answer_vld), .busy(busy), .done(done), .answer(answer),
        .err(err), .pt_cnt(pt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i);
        ld_x = DW'(3*i+1);
        ld_y = DW'(3*i+2);
        ld_z = DW'(3*i+3);
        ld_vld = 1'b1;
        if (mcnt < NP) begin
            mdl[mcnt] = '{x: ld_x, y: ld_y, z: ld_z};
            mcnt++;
        end
        @(negedge clk);
        ld_vld = 1'b0;
    endtask

    task automatic count_clr(input string tag);
        int n = 0;
        while (dp_clr && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 64'(n), 64'd4);
    endtask

    task automatic start_run(input int t);
        tmo_cycles = 32'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NP; i++) exp_q.push_back(mdl[i]);
        count_clr("clr_len");
    endtask

    task automatic stream(input bit rnd, input int abort_at);
        int hs = 0, first = -1;
        for (int c = 0; c < 400 && hs < NP; c++) begin
            locs_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (locs_vld) begin
                if (first < 0) first = c;
                if (exp_q.size() == 0) chk("pt_extra", 64'(locs_vld), 64'd0);
                else chk("pt", 64'({xloc, yloc, zloc}), 64'(exp_q[0]));
                if (locs_rdy) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
            end
            abort = abort_at > 0 && hs == abort_at && locs_vld && locs_rdy;
            @(negedge clk);
            if (abort) begin
                abort = 1'b0;
                break;
            end
        end
        locs_rdy = 1'b0;
        if (abort_at > 0) chk("vld_drop", 64'(locs_vld), 64'd0);
        else begin
            chk("hs_cnt", 64'(hs), 64'(NP));
            chk("first_vld", 64'(first >= 0 && first <= 2), 64'd1);
        end
    endtask

    task automatic give_answer(input int a);
        dp_answer = AW'(a);
        dp_answer_vld = 1'b1;
        @(negedge clk);
        dp_answer_vld = 1'b0;
        chk("done_hi", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_lo", 64'(done), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("answer", 64'(answer), 64'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ld_rdy", 64'(ld_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pt_cnt", 64'(pt_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_answer", 64'(answer), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ld_rdy_idle", 64'(ld_rdy), 64'd1);
        load(0);
        load(1);
        chk("pt_two", 64'(pt_cnt), 64'd2);
        ld_x = DW'(99);
        ld_vld = 1'b1;
        buf_clr = 1'b1;
        @(negedge clk);
        ld_vld = 1'b0;
        buf_clr = 1'b0;
        mcnt = 0;
        chk("buf_clr", 64'(pt_cnt), 64'd0);
        for (int i = 0; i < 3; i++) load(i);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("proto_err", 64'(err), 64'b100);
        chk("proto_busy", 64'(busy), 64'd0);
        load(3);
        chk("pt_full", 64'(pt_cnt), 64'd4);
        chk("ld_rdy_full", 64'(ld_rdy), 64'd0);
        ld_vld = 1'b1;
        @(negedge clk);
        ld_vld = 1'b0;
        chk("pt_sat", 64'(pt_cnt), 64'd4);

        start_run(0);
        stream(1'b0, 0);
        repeat (20) @(negedge clk);
        chk("no_tmo_busy", 64'(busy), 64'd1);
        give_answer(40);
        chk("err_run1", 64'(err), 64'd0);

        start_run(0);
        stream(1'b1, 0);
        give_answer(77);
        chk("err_run2", 64'(err), 64'd0);

        start_run(10);
        stream(1'b0, 0);
        repeat (9) @(negedge clk);
        chk("tmo_early_busy", 64'(busy), 64'd1);
        chk("tmo_early_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("tmo_err", 64'(err), 64'b010);
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_answer", 64'(answer), 64'd77);

        start_run(0);
        stream(1'b0, 2);
        count_clr("abort_clr_len");
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_err", 64'(err), 64'b001);
        chk("abort_answer", 64'(answer), 64'd77);

        start_run(0);
        stream(1'b1, 0);
        give_answer(5);
        chk("err_rerun", 64'(err), 64'd0);

        tmo_cycles = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_vld", 64'(locs_vld), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_vld", 64'(locs_vld), 64'd0);
        chk("arst_xloc", 64'(xloc), 64'd0);
        chk("arst_answer", 64'(answer), 64'd0);
        chk("arst_pt_cnt", 64'(pt_cnt), 64'd0);
        chk("arst_ld_rdy", 64'(ld_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dp_answer_vld = 1'b1;
        @(negedge clk);
        dp_answer_vld = 1'b0;
        chk("idle_ans_err", 64'(err), 64'b100);
        chk("idle_ans_answer", 64'(answer), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
